// File: rtl/alu_muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq_pkg
// Shared definitions for the sequential multiply/divide unit:
//   - FUNC_W / alu_func_e : operation codes on issue_func
//   - alu_state_e         : sequencer state encoding
//   - DATA_W_DEF, MUL_LAT_DEF : default operand width and multiply latency
//   - func_is_mul / func_is_div : operation class helpers
// ---------------------------------------------------------------------------
package alu_muldiv_seq_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int MUL_LAT_DEF = 4;
    localparam int FUNC_W      = 3;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_MULU = 3'd0,
        FUNC_MULS = 3'd1,
        FUNC_DIVU = 3'd2,
        FUNC_DIVS = 3'd3,
        FUNC_MTHI = 3'd4,
        FUNC_MTLO = 3'd5
    } alu_func_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } alu_state_e;

    function automatic logic func_is_mul(input alu_func_e f);
        return (f == FUNC_MULU) || (f == FUNC_MULS);
    endfunction

    function automatic logic func_is_div(input alu_func_e f);
        return (f == FUNC_DIVU) || (f == FUNC_DIVS);
    endfunction

endpackage

// File: rtl/alu_divstep.sv
// ---------------------------------------------------------------------------
// alu_divstep
// One combinational restoring-division iteration on unsigned magnitudes.
//   i_rem      : partial remainder entering this step (always < divisor)
//   i_bit      : next dividend bit, MSB first
//   i_divisor  : divisor magnitude
//   o_rem      : partial remainder after this step
//   o_quot_bit : quotient bit produced by this step
// ---------------------------------------------------------------------------
module alu_divstep #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_quot_bit
);

    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_diff;

    assign w_shifted  = {i_rem, i_bit};
    assign w_diff     = w_shifted - {1'b0, i_divisor};
    // Since i_rem < divisor, a non-negative difference always fits in DATA_W
    // bits, so the extra MSB is a clean borrow flag.
    assign o_quot_bit = ~w_diff[DATA_W];
    assign o_rem      = o_quot_bit ? w_diff[DATA_W-1:0] : w_shifted[DATA_W-1:0];

endmodule

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
// Sequential HI/LO multiply/divide unit (MIPS-style mult/div/mthi/mtlo/mfhi/mflo).
// Optional feature macro: ALU_MULDIV_ABORT_EN adds the abort (pipeline flush) input.
// Ports:
//   clock, reset_n          : clock (rising edge), asynchronous active-low reset
//   issue_valid/issue_ready : operation handshake; ready only in IDLE
//   issue_func              : alu_func_e code
//   data1, data2            : rs/rt operands (mthi/mtlo use data1)
//   rd_req, rd_sel          : HI/LO read request, 1 = HI, 0 = LO
//   rd_data, rd_stall       : selected HI/LO, stall while busy
//   busy, done              : operation in flight, one-cycle completion pulse
//   abort                   : flush (only with ALU_MULDIV_ABORT_EN)
// ---------------------------------------------------------------------------
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [FUNC_W-1:0] issue_func,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              rd_req,
    input  logic              rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_stall,
    output logic              busy,
    output logic              done
`ifdef ALU_MULDIV_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    alu_state_e          r_state;
    alu_func_e           r_func;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quot;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dbz;
    logic                r_done;

    alu_func_e           w_func;
    logic                w_accept;
    logic                w_abort;
    logic                w_div_signed;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;
    logic                w_sext;
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_step_rem;
    logic                w_step_q;
    logic [DATA_W-1:0]   w_fix_q;
    logic [DATA_W-1:0]   w_fix_r;

`ifdef ALU_MULDIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_func      = alu_func_e'(issue_func);
    assign issue_ready = (r_state == ST_IDLE);
    assign w_accept    = issue_valid & issue_ready;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign rd_data     = rd_sel ? r_hi : r_lo;
    assign rd_stall    = rd_req & busy;

    // Divide works on magnitudes; signs are restored in FIX.
    assign w_div_signed = (w_func == FUNC_DIVS);
    assign w_mag1 = (w_div_signed && data1[DATA_W-1]) ? (-data1) : data1;
    assign w_mag2 = (w_div_signed && data2[DATA_W-1]) ? (-data2) : data2;

    // Single 2W x 2W multiplier: sign- or zero-extending both operands makes
    // the low 2W bits of the product correct for both signed and unsigned.
    assign w_sext  = (r_func == FUNC_MULS);
    assign w_ext_a = {{DATA_W{w_sext & r_a[DATA_W-1]}}, r_a};
    assign w_ext_b = {{DATA_W{w_sext & r_b[DATA_W-1]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Dividend is held in r_quot and shifted out MSB-first while quotient
    // bits shift in from the bottom.
    alu_divstep #(
        .DATA_W (DATA_W)
    ) u_divstep (
        .i_rem      (r_rem),
        .i_bit      (r_quot[DATA_W-1]),
        .i_divisor  (r_divisor),
        .o_rem      (w_step_rem),
        .o_quot_bit (w_step_q)
    );

    assign w_fix_q = r_neg_q ? (-r_quot) : r_quot;
    assign w_fix_r = r_neg_r ? (-r_rem)  : r_rem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_func    <= FUNC_MULU;
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_func == FUNC_MTHI) begin
                            r_hi <= data1;
                        end else if (w_func == FUNC_MTLO) begin
                            r_lo <= data1;
                        end else if (func_is_mul(w_func)) begin
                            r_func  <= w_func;
                            r_a     <= data1;
                            r_b     <= data2;
                            r_cnt   <= CNT_W'(MUL_LAT - 1);
                            r_state <= ST_MUL;
                        end else if (func_is_div(w_func)) begin
                            r_func    <= w_func;
                            r_a       <= data1;
                            r_b       <= data2;
                            r_rem     <= '0;
                            r_quot    <= w_mag1;
                            r_divisor <= w_mag2;
                            r_neg_q   <= w_div_signed & (data1[DATA_W-1] ^ data2[DATA_W-1]);
                            r_neg_r   <= w_div_signed & data1[DATA_W-1];
                            r_dbz     <= (data2 == '0);
                            r_cnt     <= CNT_W'(DATA_W - 1);
                            r_state   <= ST_DIV;
                        end
                        // Undefined function codes are accepted and dropped.
                    end
                end
                ST_MUL: begin
                    if (w_abort) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (w_abort) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem  <= w_step_rem;
                        r_quot <= {r_quot[DATA_W-2:0], w_step_q};
                        if (r_cnt == '0) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                ST_FIX: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Divide by zero returns a fixed pattern rather than
                        // whatever the restoring loop left behind.
                        if (r_dbz) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_fix_r;
                            r_lo <= w_fix_q;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand B is only needed during the multiply; keep it referenced for
    // divides so the latch-on-accept behaviour is uniform.
    logic w_unused_b;
    assign w_unused_b = ^r_b;

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Parameter DATA_W, default 32: operand/HI/LO width.
REQ-002 Parameter MUL_LAT, default 4: multiply latency in cycles, range 1..8.
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 issue_valid  input  1  operation offered this cycle.
REQ-006 issue_ready  output  1  sequencer can accept an operation.
REQ-007 issue_func  input  Alu_Func width  one of Mulu, Muls, Divu, Divs, Mthi, Mtlo.
REQ-008 data1, data2  input  DATA_W each  rs/rt operands; mt* uses data1.
REQ-009 rd_req  input  1  mfhi/mflo read request; rd_sel input 1 (1=HI, 0=LO).
REQ-010 rd_data  output  DATA_W  selected HI/LO; rd_stall output 1  read must be held.
REQ-011 busy  output  1  mul/div in flight; done output 1  one-cycle completion pulse.
REQ-012 abort  input  1  pipeline flush (present only with ALU_MULDIV_ABORT_EN).

Function
REQ-013 States IDLE, MUL, DIV, FIX, DONE; issue_ready = (state==IDLE).
REQ-014 Accept = issue_valid & issue_ready; operands and func latched on accept edge.
REQ-015 Mthi/Mtlo: write data1 to HI/LO on accept edge; state stays IDLE; no done pulse.
REQ-016 Mulu/Muls: IDLE->MUL; counter runs MUL_LAT cycles; 2*DATA_W product to {HI,LO}; then DONE.
REQ-017 Divu/Divs: IDLE->DIV; one restoring step per cycle for DATA_W cycles on magnitudes; DIV->FIX.
REQ-018 FIX: signed quotient negated if operand signs differ; remainder takes dividend sign; HI=rem, LO=quot; FIX->DONE.
REQ-019 DONE lasts one cycle, done=1, returns to IDLE; divide accept-to-done = DATA_W+2 cycles.
REQ-020 Divide by zero: LO = all ones, HI = data1, same latency, no exception.
REQ-021 Divs most-negative/-1: LO = most-negative, HI = 0.
REQ-022 HI/LO updated only at DONE entry (mul/div) or mt* accept; never partially visible.
REQ-023 busy = state in {MUL, DIV, FIX, DONE}.
REQ-024 rd_data = rd_sel ? HI : LO, combinational from registers.
REQ-025 rd_stall = rd_req & busy; read in same cycle as mt* accept returns old value.
REQ-026 issue_valid while busy: not accepted, no state effect; requester holds.

Reset
REQ-027 reset_n low: state IDLE, HI=LO=0, counter=0, done=0, busy=0, issue_ready=1 after deassertion.
REQ-028 Reset mid-operation discards operation; no done pulse; HI/LO cleared.

Configuration
REQ-029 ALU_MULDIV_ABORT_EN defined: abort high in MUL/DIV/FIX -> IDLE next edge, HI/LO unchanged, no done; abort in IDLE/DONE ignored.
REQ-030 ALU_MULDIV_ABORT_EN undefined: abort port absent; operations always run to completion.

Structure
REQ-031 Alu_Func codes, state enum, and default widths live in the shared Alu package.
REQ-032 One sub-module alu_divstep: combinational single restoring division iteration (partial rem, quotient bit).

Verification
REQ-033 Divu 100/7 -> done at cycle 34 after accept; LO=14, HI=2.
REQ-034 Divs -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; Divu 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-035 Mulu 0xFFFFFFFF*2 -> after 4 cycles HI=1, LO=0xFFFFFFFE; Muls -1*-1 -> HI=0, LO=1.
REQ-036 rd_req during divide -> rd_stall=1 every busy cycle, 0 in cycle after DONE; new value read.
REQ-037 reset_n low at divide cycle 10 -> HI=LO=0, IDLE, no done; Mtlo 0x1234 next -> LO=0x1234.
REQ-038 With ALU_MULDIV_ABORT_EN: abort at divide cycle 5 -> IDLE next cycle, prior HI/LO retained.
